// File: rtl/rv32_mem_pkg.sv
// Shared load/store definitions for the RV32 data-memory path: funct3 codes,
// responder FSM encoding and access-size decode.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } acc_size_e;

    // Unsigned variants exist only for loads; a store with funct3 >= 3 is illegal.
    function automatic acc_size_e access_size(input logic we, input logic [2:0] func3);
        acc_size_e sz;
        case (func3)
            F3_B:    sz = SZ_BYTE;
            F3_H:    sz = SZ_HALF;
            F3_W:    sz = SZ_WORD;
            F3_BU:   sz = we ? SZ_BAD : SZ_BYTE;
            F3_HU:   sz = we ? SZ_BAD : SZ_HALF;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Lane select and sign/zero extension of a loaded word; shared with the
// writeback path.
module lsu_load_extend
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (func3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    result_o = word_i;
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the pipeline memory stage: valid/ready request,
// configurable wait states, one-cycle response pulse with access-fault flag.
module dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state  | meaning
    // S_IDLE | no access in flight, ready for a request
    // S_WAIT | request captured, counting down wait states
    // S_RESP | access commits on the next edge; a new request may be accepted

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          in_resp;
    logic          acc_err;
    logic          do_write;
    acc_size_e     size;
    logic [AW-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_ext;

    assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept    = req_valid && req_ready;
    assign in_resp   = (state_q == S_RESP);

    assign size     = access_size(we_q, func3_q);
    assign word_idx = addr_q[AW+1:2];

    // Out-of-range upper address bits fault rather than alias into the array.
    always_comb begin
        acc_err = 1'b0;
        case (size)
            SZ_HALF: acc_err = addr_q[0];
            SZ_WORD: acc_err = |addr_q[1:0];
            SZ_BAD:  acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
        if (addr_q[31:2] >= 30'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        wr_lane = wdata_q;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr_q[1:0];
                wr_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{wdata_q[15:0]}};
            end
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign do_write = in_resp && we_q && !acc_err;
    assign rd_word  = mem_q[word_idx];

    lsu_load_extend u_load_extend (
        .word_i    (rd_word),
        .addr_lo_i (addr_q[1:0]),
        .func3_i   (func3_q),
        .result_o  (rd_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = in_resp;
        rsp_err_d   = in_resp && acc_err;
        rsp_rdata_d = (in_resp && !we_q && !acc_err) ? rd_ext : 32'd0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            func3_q     <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                we_q    <= req_we;
                func3_q <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Array is deliberately not reset; the write is gated by a reset-cleared state.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) driven in
// turn, with a response scoreboard that also checks response timing.
module tb_dmem_responder;

    localparam int DW = 256;
    localparam int NI = 3;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    logic        clk;
    logic        rst;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [2:0]  req_func3 [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (DW),
            .WAIT_STATES (ws_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_func3 (req_func3[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Response monitor: pops the scoreboard on every pulse and checks arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (rsp_valid[k] === 1'b1) begin
                if (sb_q.size() == 0 || sb_q[0].inst != k) begin
                    n_miss++;
                    $display("FAIL unexpected_rsp inst=%0d cyc=%0d actual rdata=%08h err=%0b required no response",
                             k, cyc, rsp_rdata[k], rsp_err[k]);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_rdata[k] !== e.rdata || rsp_err[k] !== e.err || cyc != e.due) begin
                        n_miss++;
                        $display("FAIL rsp inst=%0d actual rdata=%08h err=%0b cyc=%0d required rdata=%08h err=%0b cyc=%0d",
                                 k, rsp_rdata[k], rsp_err[k], cyc, e.rdata, e.err, e.due);
                    end
                end
            end else if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'd0 || rsp_err[k] !== 1'b0) begin
                n_miss++;
                $display("FAIL idle_hold inst=%0d cyc=%0d actual valid=%0b rdata=%08h err=%0b required 0/0/0",
                         k, cyc, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
            end
        end
        if (sb_q.size() != 0 && cyc > sb_q[0].due + 2) begin
            e = sb_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL missing_rsp inst=%0d actual none by cyc=%0d required at cyc=%0d", e.inst, cyc, e.due);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Drives one request, holding valid until accepted; acc_cyc is the accepting edge.
    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_func3[k] = f3;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        while (req_ready[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready[k] !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout inst=%0d actual ready=%0b required 1", k, req_ready[k]);
            req_valid[k] = 1'b0;
            acc_cyc = -1;
            return;
        end
        sb_q.push_back('{inst: k, rdata: exp_rd, err: exp_err, due: cyc + ws_of(k) + 2});
        acc_cyc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        for (int k = 0; k < NI; k++) req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain_timeout actual pending=%0d required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a0, a1, a2;

        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_func3[k] = 3'd0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
        end

        // Reset holds everything idle even with a store presented.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_func3[0] = 3'd2;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        end
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk("reset_ready", 32'(req_ready[k]), 32'd1);

        // Instance 0, one wait state: table of stores, loads and faults.
        vt.push_back('{1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vt.push_back('{1'b0, 3'd2, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vt.push_back('{1'b1, 3'd2, 32'h20, 32'h1122_3344, 32'h0, 1'b0});
        vt.push_back('{1'b1, 3'd0, 32'h21, 32'h0000_00AB, 32'h0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 32'h22, 32'h0000_8001, 32'h0, 1'b0});
        vt.push_back('{1'b0, 3'd2, 32'h20, 32'h0,         32'h8001_AB44, 1'b0});
        vt.push_back('{1'b0, 3'd0, 32'h21, 32'h0,         32'hFFFF_FFAB, 1'b0});
        vt.push_back('{1'b0, 3'd4, 32'h21, 32'h0,         32'h0000_00AB, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h22, 32'h0,         32'hFFFF_8001, 1'b0});
        vt.push_back('{1'b0, 3'd5, 32'h22, 32'h0,         32'h0000_8001, 1'b0});
        vt.push_back('{1'b0, 3'd0, 32'h20, 32'h0,         32'h0000_0044, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h20, 32'h0,         32'hFFFF_AB44, 1'b0});
        vt.push_back('{1'b0, 3'd0, 32'h23, 32'h0,         32'hFFFF_FF80, 1'b0});
        vt.push_back('{1'b0, 3'd5, 32'h20, 32'h0,         32'h0000_AB44, 1'b0});
        vt.push_back('{1'b1, 3'd2, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 32'h31, 32'h1111_1111, 32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd2, 32'h30, 32'h0,         32'hCAFE_F00D, 1'b0});
        vt.push_back('{1'b0, 3'd1, 32'h33, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd1, 32'h21, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd3, 32'h30, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd6, 32'h30, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd7, 32'h30, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd2, DW * 4, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b0, 3'd2, 32'h8000_0010, 32'h0,  32'h0, 1'b1});
        vt.push_back('{1'b1, 3'd3, 32'h30, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b1, 3'd4, 32'h30, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b1, 3'd2, DW * 4, 32'h0,         32'h0, 1'b1});
        vt.push_back('{1'b1, 3'd0, 32'h33, 32'h0000_005A, 32'h0, 1'b0});
        vt.push_back('{1'b0, 3'd2, 32'h30, 32'h0,         32'h5AFE_F00D, 1'b0});

        for (int i = 0; i < vt.size(); i++) begin
            do_req(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err, a0);
        end
        idle();
        drain();

        // Instance 1, no wait states: back-to-back with valid held high.
        do_req(1, 1'b1, 3'd2, 32'h40, 32'd5, 32'd0, 1'b0, a0);
        do_req(1, 1'b0, 3'd2, 32'h40, 32'd0, 32'd5, 1'b0, a1);
        do_req(1, 1'b0, 3'd0, 32'h40, 32'd0, 32'd5, 1'b0, a2);
        idle();
        chk("b2b_accept_gap_1", 32'(a1 - a0), 32'd1);
        chk("b2b_accept_gap_2", 32'(a2 - a1), 32'd1);
        drain();

        // Instance 2, three wait states: ready pattern after a single accept.
        do_req(2, 1'b1, 3'd2, 32'h48, 32'h0000_0077, 32'd0, 1'b0, a0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[2] = 1'b0;
            chk($sformatf("ws3_ready_c%0d", i), 32'(req_ready[2]), (i == 4) ? 32'd1 : 32'd0);
        end
        drain();

        // Request held through WAIT is taken in the RESP cycle and sees the store.
        do_req(2, 1'b1, 3'd2, 32'h44, 32'hA5A5_0F0F, 32'd0, 1'b0, a0);
        do_req(2, 1'b0, 3'd2, 32'h44, 32'd0, 32'hA5A5_0F0F, 1'b0, a1);
        idle();
        chk("ws3_held_accept_gap", 32'(a1 - a0), 32'd4);
        drain();

        // Reset during WAIT discards the pending store.
        do_req(2, 1'b1, 3'd2, 32'h50, 32'h0000_0011, 32'd0, 1'b0, a0);
        idle();
        drain();
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_func3[2] = 3'd2;
        req_addr[2]  = 32'h50;
        req_wdata[2] = 32'h0000_00FF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("midrst_in_wait_ready", 32'(req_ready[2]), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_idle_ready", 32'(req_ready[2]), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("midrst_post_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        chk("midrst_post_ready", 32'(req_ready[2]), 32'd1);
        do_req(2, 1'b0, 3'd2, 32'h50, 32'd0, 32'h0000_0011, 1'b0, a0);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target serving the load/store requests issued by the pipeline's memory stage.
- Uses a valid/ready request channel and a one-cycle response pulse.
- Wait-state latency is configurable, so the pipeline can be verified against non-zero-latency memory.
- Decodes func3 and address low bits into byte/halfword/word accesses, applies load sign/zero extension, and flags misaligned, illegal or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the backing array. Power of two, 4..65536.
- WAIT_STATES, 1: extra cycles between request acceptance and response. Range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data. 0 for stores and errors.
- rsp_err  out  1  access fault, valid with rsp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers cleared.
  - The memory array is not reset.
  - Any pending store is discarded. No write occurs on the edge where reset is active.
- FSM states and transitions:
  - IDLE -> WAIT on accept when WAIT_STATES>0. IDLE -> RESP on accept when WAIT_STATES=0.
  - WAIT counts WAIT_STATES edges, then goes to RESP.
  - RESP -> WAIT or RESP on a new accept, otherwise RESP -> IDLE.
- Handshake:
  - req_ready = (state==IDLE) || (state==RESP). It is combinational from state only, with no dependence on req_valid.
  - Accept happens when req_valid && req_ready at a rising edge. we, func3, addr and wdata are captured on that edge.
- Latency:
  - rsp_valid is high for exactly one cycle, WAIT_STATES+1 cycles after the accepting edge.
  - No response back-pressure.
  - Back-to-back throughput is one access per WAIT_STATES+1 cycles. With WAIT_STATES=0, one access per cycle.
- Commit timing: a store writes the array on the same edge that raises rsp_valid, and a load samples the array on that edge. A load accepted in the RESP cycle of a store to the same word therefore returns the new data.
- Error conditions (any one sets rsp_err=1, suppresses the write, and forces rsp_rdata=0):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load func3 in {3,6,7}.
  - Store func3 >= 3.
  - addr[31:2] >= DEPTH_WORDS.
- Store byte enables:
  - SB: the byte at addr[1:0] gets wdata[7:0].
  - SH: bytes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - SW: all four bytes.
  - Unselected bytes are preserved.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW returns the word unchanged.
- Output holding: rsp_rdata and rsp_err return to 0 when rsp_valid=0.
- Address width: word index = addr[log2(DEPTH_WORDS)+1:2] after the range check. Upper bits beyond the range are an error, never aliased.

Decomposition:
- Shared package `rv32_mem_pkg`:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - FSM state encoding IDLE/WAIT/RESP.
  - Access-size decode function.
- Sub-module `lsu_load_extend` (combinational): takes a 32-bit word, addr[1:0] and func3, and produces the extended 32-bit result. It is reused later by the writeback path.

Test Plan:
- Reset: with rst=0, drive req_valid=1 -> rsp_valid=0, req_ready=1 after release, no array write. Then SW 0x0000_0010 <- 0xDEADBEEF followed by LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, exactly WAIT_STATES+1 cycles after each accept.
- Byte/half stores and extension:
  - Stores: SW 0x20 <- 0x11223344, then SB 0x21 <- 0xAB, then SH 0x22 <- 0x8001.
  - Word readback: LW 0x20 -> 0x8001AB44.
  - LB 0x21 -> 0xFFFFFFAB. LBU 0x21 -> 0x000000AB.
  - LH 0x22 -> 0xFFFF8001. LHU 0x22 -> 0x00008001.
- Faults:
  - SW 0x31 -> rsp_err=1, and a later LW 0x30 is unchanged.
  - LH 0x33 -> err.
  - LW with func3=3 -> err.
  - LW addr=DEPTH_WORDS*4 -> err, rsp_rdata=0.
- Back-to-back with WAIT_STATES=0: req_valid held high for SW 0x40 <- 5 then LW 0x40 on consecutive cycles -> req_ready stays 1, and the second response returns 5.
- Wait states with WAIT_STATES=3: req_ready=0 for 3 cycles after accept, and rsp_valid is high in cycle 4 only. A request held during the WAIT cycles is accepted in the RESP cycle.
- Reset mid-operation with WAIT_STATES=3: assert rst during WAIT of SW 0x50 <- 0xFF -> no rsp_valid, LW 0x50 returns the prior value, FSM is in IDLE.
